// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver for one rx pin.
// The rx pin passes through a 2-FF synchronizer. Each bit is sampled mid-bit by a
// clk_cnt bit timer. A good byte is presented on rx_data with a one-cycle
// rx_data_rdy strobe.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, the frame is 8E1
// and parity_err reports a parity mismatch. When it is undefined, the frame is 8N1
// and parity_err is tied to 0.
// Handshake: rx_data_rdy, frame_err and parity_err are valid-only strobes with no
// ready. Each is high for exactly one cycle. They are mutually exclusive. rx_data
// is already updated in the same cycle as rx_data_rdy. A consumer that misses a
// strobe loses that byte.
module uart_rx_byte #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    state_t           state, state_next;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             cnt_last;
    logic             cnt_clr;
    logic             shift_en;
    logic             done_ok;
    logic             done_ferr;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit;
    logic             par_en;
    logic             par_bad;
    logic             done_perr;
`endif

    assign cnt_last  = (clk_cnt == CNT_LAST);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
`ifdef UART_RX_PARITY_EN
    // Even parity: data bits and parity bit together must XOR to 0.
    assign par_bad = ^{shift_reg, parity_bit};
`endif

    // Two-flop synchronizer. It resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic and the per-cycle datapath controls.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        done_ok    = 1'b0;
        done_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en     = 1'b0;
        done_perr  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                // Check the middle of the start bit. A high line here means a glitch.
                if (clk_cnt == CNT_HALF) begin
                    if (rx_s) begin
                        state_next = S_IDLE;
                    end else begin
                        cnt_clr    = 1'b1;
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_next = S_PARITY;
`else
                    if (bit_idx == 3'd7) state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_last) begin
                    par_en     = 1'b1;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid stop bit so an immediate next start edge is caught.
                if (cnt_last) begin
                    if (!rx_s) begin
                        done_ferr  = 1'b1;
                        state_next = S_WAIT_HI;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        done_perr  = 1'b1;
                        state_next = S_IDLE;
`endif
                    end else begin
                        done_ok    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_WAIT_HI: begin
                // After a low stop bit, wait for the line to return high before rearming.
                cnt_clr = 1'b1;
                if (rx_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bit timer, bit index, shift register and the registered output strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_cnt     <= '0;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'h00;
            rx_data     <= 8'h00;
            rx_data_rdy <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            clk_cnt <= (cnt_clr || cnt_last) ? '0 : clk_cnt + 1'b1;
            if (state == S_IDLE)  bit_idx <= 3'd0;
            else if (shift_en)    bit_idx <= bit_idx + 3'd1;
            if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
            if (done_ok)  rx_data   <= shift_reg;
            rx_data_rdy <= done_ok;
            frame_err   <= done_ferr;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity bit capture and the parity error strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_bit <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_en) parity_bit <= rx_s;
            parity_err <= done_perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
